// File: rtl/fir_pkg.sv
// Shared helpers for the transposed FIR: width derivation and the round/saturate function.
package fir_pkg;

    localparam int WIDE_W = 64;

    typedef struct packed {
        logic                     sat;
        logic signed [WIDE_W-1:0] value;
    } sat_res_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Accumulator wide enough that a full sum of products never wraps.
    function automatic int acc_width(input int data_w, input int coeff_w, input int taps);
        return data_w + coeff_w + clog2(taps);
    endfunction

    // Round half up, arithmetic shift, then clip to an out_w-bit signed range.
    function automatic sat_res_t sat_round(input logic signed [WIDE_W-1:0] acc,
                                           input int shift, input int out_w);
        logic signed [WIDE_W:0] sum;
        logic signed [WIDE_W:0] r;
        logic signed [WIDE_W:0] hi;
        logic signed [WIDE_W:0] lo;
        sat_res_t               res;
        sum = {acc[WIDE_W-1], acc};
        if (shift > 0) sum = sum + (65'sd1 <<< (shift - 1));
        r  = sum >>> shift;
        hi = (65'sd1 <<< (out_w - 1)) - 65'sd1;
        lo = -(65'sd1 <<< (out_w - 1));
        if (r > hi) begin
            res.sat   = 1'b1;
            res.value = hi[WIDE_W-1:0];
        end else if (r < lo) begin
            res.sat   = 1'b1;
            res.value = lo[WIDE_W-1:0];
        end else begin
            res.sat   = 1'b0;
            res.value = r[WIDE_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/fir_tap.sv
// One transposed-form MAC cell: registered product, then accumulate into the partial sum.
module fir_tap #(
    parameter int DATA_W  = 12,
    parameter int COEFF_W = 16,
    parameter int ACC_W   = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               en,
    input  logic               clear,
    input  logic [COEFF_W-1:0] coeff,
    input  logic [DATA_W-1:0]  x,
    input  logic [ACC_W-1:0]   acc_in,
    output logic [ACC_W-1:0]   acc_out
);

    logic signed [DATA_W+COEFF_W-1:0] prod;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prod    <= '0;
            acc_out <= '0;
        end else begin
            prod <= $signed(coeff) * $signed(x);
            if (clear) begin
                acc_out <= '0;
            end else if (en) begin
                acc_out <= acc_in + ACC_W'(prod);
            end
        end
    end

endmodule

// File: rtl/fir_transposed_filter.sv
// Transposed-form FIR with valid-qualified flow, double-buffered coefficients and
// rounded/saturated output. Four register stages from in_valid to out_valid.
module fir_transposed_filter
    import fir_pkg::*;
#(
    parameter int TAPS      = 16,
    parameter int DATA_W    = 12,
    parameter int COEFF_W   = 16,
    parameter int OUT_W     = 16,
    parameter int OUT_SHIFT = 15
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [DATA_W-1:0]      in_data,
    input  logic                   cfg_we,
    input  logic [clog2(TAPS)-1:0] cfg_addr,
    input  logic [COEFF_W-1:0]     cfg_data,
    input  logic                   cfg_commit,
    input  logic                   clear,
    output logic                   out_valid,
    output logic [OUT_W-1:0]       out_data,
    output logic                   out_sat
);

    localparam int ACC_W  = acc_width(DATA_W, COEFF_W, TAPS);
    localparam int ADDR_W = clog2(TAPS);

    // in_valid/out_valid are pure qualifiers: there is no ready, every offered sample is taken.
    logic [DATA_W-1:0]            x_d;
    logic                         v1, v2, v3;
    logic [COEFF_W-1:0]           shadow [TAPS];
    logic [COEFF_W-1:0]           active [TAPS];
    logic [TAPS:0][ACC_W-1:0]     acc_chain;
    sat_res_t                     res;
    logic                         unused_res_hi;

    assign acc_chain[TAPS] = '0;

    for (genvar k = 0; k < TAPS; k++) begin : g_tap
        fir_tap #(
            .DATA_W (DATA_W),
            .COEFF_W(COEFF_W),
            .ACC_W  (ACC_W)
        ) u_tap (
            .clock  (clock),
            .reset  (reset),
            .en     (v2),
            .clear  (clear),
            .coeff  (active[k]),
            .x      (x_d),
            .acc_in (acc_chain[k+1]),
            .acc_out(acc_chain[k])
        );
    end

    always_comb begin
        res = sat_round(WIDE_W'($signed(acc_chain[0])), OUT_SHIFT, OUT_W);
    end

    assign unused_res_hi = ^res.value[WIDE_W-1:OUT_W];

    // A commit copies the bank as it stood before this edge, so a same-cycle write lands in shadow only.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < TAPS; k++) begin
                shadow[k] <= '0;
                active[k] <= '0;
            end
        end else begin
            for (int k = 0; k < TAPS; k++) begin
                if (cfg_commit) active[k] <= shadow[k];
                if (cfg_we && cfg_addr == ADDR_W'(k)) shadow[k] <= cfg_data;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x_d       <= '0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            v3        <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else begin
            if (in_valid) x_d <= in_data;
            v1        <= in_valid & ~clear;
            v2        <= v1 & ~clear;
            v3        <= v2 & ~clear;
            out_valid <= v3 & ~clear;
            if (v3 && !clear) begin
                out_data <= res.value[OUT_W-1:0];
                out_sat  <= res.sat;
            end
        end
    end

endmodule
